// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - shared widths, states and helpers for the small fp adder
//
// Purpose: default operand geometry, controller state encoding, special
// operand constants and the mantissa extraction helper.
// Ports: none (package).
package fp8_pkg;

  localparam int DEF_EXP_W  = 4;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OP_W   = DEF_EXP_W + DEF_FRAC_W;
  localparam int DEF_MANT_W = DEF_FRAC_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } fp_state_e;

  localparam logic [DEF_OP_W-1:0] FP_ZERO = '0;
  localparam logic [DEF_OP_W-1:0] FP_SAT  = '1;

  // The all-zeros encoding is exact zero, so it carries no hidden bit.
  function automatic logic [DEF_MANT_W-1:0] mant_of(input logic [DEF_OP_W-1:0] op);
    return {op != FP_ZERO, op[DEF_FRAC_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// rtl/fp_align_shift.sv - loadable mantissa right-shifter with down-counter
//
// Purpose: holds the smaller mantissa and shifts it right one bit per cycle
// (zero fill, bits shifted out are dropped) until the counter reaches zero.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load mant_in/count_in (takes priority over shifting)
//   mant_in     mantissa to align
//   count_in    number of shift steps to perform
//   mant_out    current (partially) aligned mantissa
//   zero_count  counter is at zero or the shift on this edge is the last one
module fp_align_shift #(
  parameter int MANT_W = 5,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic [MANT_W-1:0] mant_out,
  output logic              zero_count
);

  logic [MANT_W-1:0] mant_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      mant_q <= mant_in;
      cnt_q  <= count_in;
    end else if (cnt_q != '0) begin
      mant_q <= mant_q >> 1;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign mant_out = mant_q;
  // Flags the 1->0 step so the controller can leave ALIGN on that same edge.
  assign zero_count = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// rtl/fp_add_seq_ctrl.sv - multi-cycle sequencer for the small fp adder
//
// Purpose: accepts {exp, frac} operands, orders them, aligns the smaller
// mantissa one bit per cycle, adds, normalizes and returns a truncated sum.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b                operands {exp, frac}
//   res_valid/res_ready result handshake (valid only in DONE)
//   result              sum {exp, frac}; all-ones when saturated
//   overflow            exponent overflow, qualified by res_valid
//   busy                any state other than IDLE
module fp_add_seq_ctrl
  import fp8_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W-1:0] a,
  input  logic [EXP_W+FRAC_W-1:0] b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [EXP_W+FRAC_W-1:0] result,
  output logic                    overflow,
  output logic                    busy
);

  localparam int OP_W   = EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  fp_state_e state_q, state_d;

  logic [OP_W-1:0]   a_q, b_q;
  logic [EXP_W-1:0]  exp_big_q;
  logic [MANT_W-1:0] mant_big_q;
  logic [MANT_W:0]   sum_q;
  logic [OP_W-1:0]   result_q;
  logic              overflow_q;

  logic              a_wins;
  logic [OP_W-1:0]   op_big, op_small;
  logic [EXP_W-1:0]  exp_diff;
  logic [CNT_W-1:0]  align_cnt;
  logic [MANT_W-1:0] mant_small;
  logic              zero_count;

  // Ordering: larger exponent, then larger fraction; a full tie goes to A.
  always_comb begin
    a_wins    = (a_q[OP_W-1:FRAC_W] > b_q[OP_W-1:FRAC_W]) ||
                ((a_q[OP_W-1:FRAC_W] == b_q[OP_W-1:FRAC_W]) &&
                 (a_q[FRAC_W-1:0] >= b_q[FRAC_W-1:0]));
    op_big    = a_wins ? a_q : b_q;
    op_small  = a_wins ? b_q : a_q;
    // A zero smaller operand needs no alignment at all.
    exp_diff  = (op_small == '0) ? '0 : (op_big[OP_W-1:FRAC_W] - op_small[OP_W-1:FRAC_W]);
    // Past MANT_W shifts the mantissa is already zero, so cap the walk.
    if (int'(exp_diff) > MANT_W) align_cnt = CNT_W'(MANT_W);
    else                         align_cnt = CNT_W'(exp_diff);
  end

  fp_align_shift #(
    .MANT_W (MANT_W),
    .CNT_W  (CNT_W)
  ) u_align (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state_q == ST_COMPARE),
    .mant_in    (mant_of(op_small)),
    .count_in   (align_cnt),
    .mant_out   (mant_small),
    .zero_count (zero_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_COMPARE;
      end
      ST_COMPARE: state_d = (align_cnt == '0) ? ST_ADD : ST_ALIGN;
      ST_ALIGN:   if (zero_count) state_d = ST_ADD;
      ST_ADD:     state_d = ST_NORM;
      ST_NORM:    state_d = ST_DONE;
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      exp_big_q  <= '0;
      mant_big_q <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        ST_COMPARE: begin
          exp_big_q  <= op_big[OP_W-1:FRAC_W];
          mant_big_q <= mant_of(op_big);
        end
        ST_ADD: sum_q <= {1'b0, mant_big_q} + {1'b0, mant_small};
        ST_NORM: begin
          if (sum_q[MANT_W]) begin
            if (exp_big_q == '1) begin
              result_q   <= FP_SAT;
              overflow_q <= 1'b1;
            end else begin
              result_q   <= {exp_big_q + EXP_W'(1), sum_q[FRAC_W:1]};
              overflow_q <= 1'b0;
            end
          end else begin
            result_q   <= {exp_big_q, sum_q[FRAC_W-1:0]};
            overflow_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// tb/tb_fp_add_seq_ctrl.sv - scoreboard bench for fp_add_seq_ctrl
module tb_fp_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] result;
  logic       overflow;
  logic       busy;

  fp_add_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pc = 0;
  bit   bp_mode = 1'b0;
  bit   holding = 1'b0;

  always @(posedge clk) pc <= pc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: value = mantissa * 2^exp; the smaller mantissa loses bits
  // below the larger operand's LSB, and the sum is renormalized once.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ex, ey, fx, fy, mx, my, eb, es, mb, ms, d, sh, sum;
    bit x_big;
    ex = int'(x[7:4]); fx = int'(x[3:0]);
    ey = int'(y[7:4]); fy = int'(y[3:0]);
    mx = (x == 8'h00) ? 0 : 16 + fx;
    my = (y == 8'h00) ? 0 : 16 + fy;
    x_big = (ex > ey) || (ex == ey && fx >= fy);
    eb = x_big ? ex : ey;  es = x_big ? ey : ex;
    mb = x_big ? mx : my;  ms = x_big ? my : mx;
    d  = (ms == 0) ? 0 : eb - es;
    sh = (d > 5) ? 5 : d;
    sum = mb + (ms >> sh);
    if (sum >= 32) begin
      if (eb == 15) begin
        e.res = 8'hFF; e.ovf = 1'b1;
      end else begin
        e.res = 8'((eb + 1) * 16 + ((sum >> 1) % 16)); e.ovf = 1'b0;
      end
    end else begin
      e.res = 8'(eb * 16 + (sum % 16)); e.ovf = 1'b0;
    end
    e.lat = 3 + sh;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: pops on the first cycle of each result and owns res_ready.
  initial begin
    exp_t cur;
    int   hold_left;
    bit   pending_hs;
    cur = '{8'h00, 1'b0, 0, 0};
    hold_left = 0;
    pending_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
        pending_hs = 1'b0;
        res_ready = 1'b0;
      end else if (pending_hs) begin
        check("idle_after_hs_in_ready", in_ready, 1);
        check("idle_after_hs_res_valid", res_valid, 0);
        pending_hs = 1'b0;
        holding = 1'b0;
        res_ready = 1'b0;
      end else if (res_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", result);
          end else begin
            cur = sb.pop_front();
            holding = 1'b1;
            hold_left = bp_mode ? 4 : int'($urandom_range(0, 2));
            check("latency", pc - cur.acc, cur.lat);
          end
        end
        if (holding) begin
          check("result", result, cur.res);
          check("overflow", overflow, cur.ovf);
          check("in_ready_in_done", in_ready, 0);
          check("busy_in_done", busy, 1);
          if (hold_left == 0) begin
            res_ready = 1'b1;
            pending_hs = 1'b1;
          end else begin
            hold_left--;
          end
        end
      end else if (holding) begin
        checks++;
        errors++;
        $display("FAIL res_valid_dropped actual=0 required=1");
        holding = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      a = x;
      b = y;
      in_valid = 1'b1;
      e.acc = pc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || holding) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || holding) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } dir_t;

  dir_t dirs[$] = '{
    '{8'h30, 8'h30, 8'h40, 1'b0, 3},
    '{8'h38, 8'h10, 8'h3C, 1'b0, 5},
    '{8'h10, 8'h38, 8'h3C, 1'b0, 5},
    '{8'hA0, 8'h20, 8'hA0, 1'b0, 8},
    '{8'hF8, 8'hF8, 8'hFF, 1'b1, 3},
    '{8'h00, 8'h57, 8'h57, 1'b0, 3},
    '{8'h00, 8'h00, 8'h00, 1'b0, 3}
  };

  initial begin
    exp_t e;
    logic [7:0] x, y;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_res_valid", res_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_res_valid", res_valid, 0);
    check("post_reset_result", result, 0);
    check("post_reset_overflow", overflow, 0);
    check("post_reset_busy", busy, 0);

    foreach (dirs[i]) begin
      e = '{dirs[i].res, dirs[i].ovf, dirs[i].lat, 0};
      send(dirs[i].x, dirs[i].y, e);
      drain();
    end

    bp_mode = 1'b1;
    e = '{8'h3C, 1'b0, 5, 0};
    send(8'h38, 8'h10, e);
    e = '{8'h40, 1'b0, 3, 0};
    send(8'h30, 8'h30, e);
    drain();
    bp_mode = 1'b0;

    // Reset lands in the second ALIGN cycle of 0x38 + 0x10.
    e = '{8'h3C, 1'b0, 5, 0};
    send(8'h38, 8'h10, e);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = '{8'h40, 1'b0, 3, 0};
    send(8'h30, 8'h30, e);
    drain();

    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bp_mode = ($urandom_range(0, 4) == 0);
      send(x, y, model(x, y));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=0", sb.size());
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_add_seq_ctrl.md
Name: fp_add_seq_ctrl

Overview:
- Multi-cycle sequencer for the small floating-point adder datapath.
- Accepts two packed operands {exp, frac} over a valid/ready handshake, then selects the larger operand by exponent (fraction as tie-break).
- Aligns the smaller mantissa one bit per cycle, adds, normalizes, and presents the result over a second valid/ready handshake.
- Sits between the operand source (switch/register stage) and the result display/register stage.

Parameters:
- EXP_W, 4, exponent width (unsigned, no bias handling).
- FRAC_W, 4, stored fraction width. Mantissa = {hidden 1, frac}, FRAC_W+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  EXP_W+FRAC_W  operand A, {exp, frac}.
- b  in  EXP_W+FRAC_W  operand B, {exp, frac}.
- res_valid  out  1  result valid; high only in DONE.
- res_ready  in  1  consumer accepts result.
- result  out  EXP_W+FRAC_W  sum, {exp, frac}, truncated.
- overflow  out  1  exponent overflowed; result saturated. Qualified by res_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers cleared.
  - in_ready=1 after reset release; res_valid=0, result=0, overflow=0, busy=0.
  - Asserting reset in any state, including mid-ALIGN or DONE, aborts the operation immediately. No partial result is emitted.
- States: IDLE, COMPARE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a and b, go to COMPARE.
- COMPARE:
  - Bigger operand = larger exponent. On equal exponents, the larger fraction wins; on a full tie, A wins.
  - d = exp_big - exp_small, unsigned EXP_W bits.
  - Zero rule: an operand equal to all-zeros is exact zero. Its mantissa is 0 (no hidden bit) and d is forced to 0.
  - Load mant_small and align count = min(d, FRAC_W+1).
  - If count=0 go to ADD, else go to ALIGN.
- ALIGN:
  - Each cycle: mant_small >>= 1 (zero fill, truncation), count -= 1.
  - Leave for ADD on the cycle count goes 1→0. Occupies exactly count cycles.
  - With d ≥ FRAC_W+1, mant_small reaches 0.
- ADD:
  - sum = mant_big + mant_small, FRAC_W+2 bits.
- NORM:
  - If sum MSB (carry) = 1: frac = sum[FRAC_W:1], exp = exp_big+1.
    - If exp_big is the all-ones value: result = all-ones and overflow=1.
  - Otherwise: frac = sum[FRAC_W-1:0], exp = exp_big.
  - Register result; go to DONE.
- DONE:
  - res_valid=1; result and overflow held stable while res_ready=0.
  - When res_ready=1: go to IDLE; res_valid drops next cycle.
  - in_ready=0 in DONE, so a new operation cannot be accepted in the same cycle.
- Latency: res_valid rises 3 + min(d, FRAC_W+1) clock edges after the accepting edge.
- Operands are sampled only at the accepting edge. Changes on a/b while busy have no effect.

Decomposition:
- Package fp8_pkg:
  - EXP_W and FRAC_W defaults.
  - State enum fp_state_e (IDLE..DONE).
  - Constants FP_ZERO (all-zeros) and FP_SAT (all-ones).
  - Function mant_of(op), returning {op≠0, frac}.
- Sub-module fp_align_shift:
  - Loadable mantissa right-shift register with down-counter.
  - Inputs: load, mant_in, count_in. Outputs: mant_out, zero_count.
- The controller FSM plus compare/add/normalize logic stays in fp_add_seq_ctrl.

Test Plan:
- Equal exponents, carry out: a=8'h30, b=8'h30 → result=8'h40, overflow=0, res_valid exactly 3 edges after accept.
- Alignment by 2: a=8'h38, b=8'h10 → result=8'h3C; exactly 2 cycles in ALIGN; latency 5. Swapping a and b gives the same result.
- Large exponent gap: a=8'hA0, b=8'h20 (d=8) → ALIGN capped at 5 cycles, result=8'hA0, latency 8.
- Overflow and zero operand:
  - a=8'hF8, b=8'hF8 → result=8'hFF, overflow=1.
  - a=8'h00, b=8'h57 → result=8'h57, overflow=0, latency 3.
  - a=b=8'h00 → result=8'h00.
- Backpressure: hold res_ready=0 for 4 cycles in DONE → result and res_valid stable, in_ready=0. Pulse res_ready → IDLE next edge; next operand accepted the edge after.
- Reset mid-operation: assert rst_n=0 during the 2nd ALIGN cycle of the 8'h38+8'h10 case → immediately IDLE, res_valid=0, busy=0. After release, 8'h30+8'h30 completes correctly with 8'h40.
